// File: rtl/fa_pkg.sv
// Shared defaults and helpers for the frequency/amplitude regulator.
package fa_pkg;

  localparam int W_DEF         = 3;
  localparam int F_INIT_DEF    = 4;
  localparam int A_INIT_DEF    = 4;
  localparam int DECAY_CYC_DEF = 4;

  // The decay counter runs 0..cyc-1, so clog2(cyc) bits suffice; keep at least one bit.
  function automatic int dc_width(input int cyc);
    int w;
    w = $clog2(cyc);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: one history flop, rise is high for the cycle the input first samples 1.
module edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic in_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) hist_q <= RST_VAL;
    else         hist_q <= in_i;
  end

  assign rise_o = in_i & ~hist_q;

endmodule

// File: rtl/fa_regulator.sv
// Frequency/amplitude regulator: edge-triggered up/down counters, f latches at zero,
// a then decays every DECAY_CYC cycles until the block is stopped and awaits a start.
module fa_regulator
  import fa_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int F_INIT    = F_INIT_DEF,
  parameter int A_INIT    = A_INIT_DEF,
  parameter int A_MAX     = 2**W - 1,
  parameter int DECAY_CYC = DECAY_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         f_up,
  input  logic         f_down,
  input  logic         a_up,
  input  logic         a_down,
  input  logic         start,
  output logic [W-1:0] f,
  output logic [W-1:0] a,
  output logic         f_zero,
  output logic         a_zero,
  output logic         f_at_max,
  output logic         a_at_max,
  output logic         stopped
);

  localparam int             DCW      = dc_width(DECAY_CYC);
  localparam logic [W-1:0]   F_INIT_V = W'(F_INIT);
  localparam logic [W-1:0]   A_INIT_V = W'(A_INIT);
  localparam logic [W-1:0]   A_MAX_V  = W'(A_MAX);
  localparam logic [DCW-1:0] DC_LAST  = DCW'(DECAY_CYC - 1);

  if (F_INIT > 2**W - 1 || A_INIT > A_MAX || A_MAX > 2**W - 1 || DECAY_CYC < 1) begin : g_param_err
    $error("fa_regulator: illegal parameter combination");
  end

  // Request bits: 0 f_up, 1 f_down, 2 a_up, 3 a_down, 4 start.
  logic [4:0] req_lvl;
  logic [4:0] req_ev;
  assign req_lvl = {start, a_down, a_up, f_down, f_up};

  for (genvar i = 0; i < 5; i++) begin : g_edge
    edge_det #(.RST_VAL(1'b1)) u_edge_det (
      .clk_i  (clk),
      .reset_i(reset),
      .in_i   (req_lvl[i]),
      .rise_o (req_ev[i])
    );
  end

  logic [W-1:0]   f_q, f_d;
  logic [W-1:0]   a_q, a_d;
  logic [DCW-1:0] dc_q, dc_d;
  logic           decay_active, decay_tick, a_inc, a_dec;

  assign f_zero   = (f_q == '0);
  assign a_zero   = (a_q == '0);
  assign f_at_max = (f_q == '1);
  assign a_at_max = (a_q == A_MAX_V);
  assign stopped  = f_zero && a_zero;

  assign decay_active = f_zero && !a_zero;
  assign decay_tick   = decay_active && (dc_q == DC_LAST);
  // a_up is meaningless once f has latched at zero; decay ticks only exist then.
  assign a_inc        = req_ev[2] && !f_zero;
  assign a_dec        = req_ev[3] || decay_tick;

  always_comb begin
    f_d  = f_q;
    a_d  = a_q;
    dc_d = dc_q;
    if (req_ev[4] && stopped) begin
      f_d  = F_INIT_V;
      a_d  = A_INIT_V;
      dc_d = '0;
    end else begin
      if (!f_zero) begin
        if (req_ev[0] && !req_ev[1] && !f_at_max) f_d = f_q + W'(1);
        else if (req_ev[1] && !req_ev[0])         f_d = f_q - W'(1);
      end
      if (a_inc && !a_dec) begin
        if (!a_at_max) a_d = a_q + W'(1);
      end else if (a_dec && !a_inc) begin
        if (!a_zero) a_d = a_q - W'(1);
      end
      dc_d = (!decay_active || decay_tick) ? '0 : dc_q + DCW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q  <= F_INIT_V;
      a_q  <= A_INIT_V;
      dc_q <= '0;
    end else begin
      f_q  <= f_d;
      a_q  <= a_d;
      dc_q <= dc_d;
    end
  end

  assign f = f_q;
  assign a = a_q;

endmodule

// File: tb/tb_fa_regulator.sv
// Bench for fa_regulator: directed scenarios plus random request levels, scored against a reference model.
module tb_fa_regulator;

  localparam int W     = 3;
  localparam int FMAX  = 7;
  localparam int AMAX  = 7;
  localparam int FINIT = 4;
  localparam int AINIT = 4;
  localparam int DECAY = 4;
  localparam int EW    = 2*W + 5;

  localparam logic [4:0] M_FUP = 5'b00001;
  localparam logic [4:0] M_FDN = 5'b00010;
  localparam logic [4:0] M_AUP = 5'b00100;
  localparam logic [4:0] M_ADN = 5'b01000;
  localparam logic [4:0] M_STA = 5'b10000;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [4:0]   req   = M_FUP;
  logic [W-1:0] f, a;
  logic         f_zero, a_zero, f_at_max, a_at_max, stopped;

  fa_regulator dut (
    .clk     (clk),
    .reset   (reset),
    .f_up    (req[0]),
    .f_down  (req[1]),
    .a_up    (req[2]),
    .a_down  (req[3]),
    .start   (req[4]),
    .f       (f),
    .a       (a),
    .f_zero  (f_zero),
    .a_zero  (a_zero),
    .f_at_max(f_at_max),
    .a_at_max(a_at_max),
    .stopped (stopped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] dut_vec;
  assign dut_vec = {f, a, f_zero, a_zero, f_at_max, a_at_max, stopped};

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [EW-1:0] pack_exp(input int ef, input int ea);
    return {W'(ef), W'(ea), ef == 0, ea == 0, ef == FMAX, ea == AMAX, (ef == 0 && ea == 0)};
  endfunction

  // Reference model: f/a as integers, decay as a count of cycles spent decaying.
  int         mf, ma, mdc;
  logic [4:0] mprev;
  always @(posedge clk or posedge reset) begin : model
    logic [4:0] ev;
    int         of;
    bit         tick;
    if (reset) begin
      mf = FINIT; ma = AINIT; mdc = 0; mprev = '1;
    end else begin
      ev    = req & ~mprev;
      mprev = req;
      if (ev[4] && mf == 0 && ma == 0) begin
        mf = FINIT; ma = AINIT; mdc = 0;
      end else begin
        of   = mf;
        tick = 1'b0;
        if (of == 0 && ma != 0) begin
          mdc++;
          if (mdc == DECAY) begin tick = 1'b1; mdc = 0; end
        end else begin
          mdc = 0;
        end
        if (of != 0) mf = clamp(of + int'(ev[0]) - int'(ev[1]), 0, FMAX);
        ma = clamp(ma + int'(ev[2] && of != 0) - int'(ev[3] || tick), 0, AMAX);
      end
      exp_q.push_back(pack_exp(mf, ma));
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (dut_vec !== exp_v) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got f=%0d a=%0d flags=%b exp f=%0d a=%0d flags=%b",
                 $time, dut_vec[EW-1 -: W], dut_vec[4 +: W], dut_vec[4:0],
                 exp_v[EW-1 -: W], exp_v[4 +: W], exp_v[4:0]);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic pulse(input logic [4:0] m);
    req = req | m;
    @(negedge clk);
    req = req & ~m;
    @(negedge clk);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("reset_f", int'(f), FINIT);
    check("reset_a", int'(a), AINIT);
    check("reset_stopped", int'(stopped), 0);
    check("reset_f_zero", int'(f_zero), 0);
    check("reset_a_zero", int'(a_zero), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("held_through_reset_f", int'(f), FINIT);
    req = '0;
    @(negedge clk);

    req = M_FDN;
    @(negedge clk);
    check("fdown_held_first", int'(f), 3);
    repeat (9) @(negedge clk);
    check("fdown_held_after", int'(f), 3);
    req = '0;
    @(negedge clk);
    pulse(M_FUP);
    check("back_to_4", int'(f), 4);

    for (int i = 0; i < 5; i++) begin
      pulse(M_FUP);
      check("fup_step", int'(f), (5 + i > FMAX) ? FMAX : 5 + i);
      if (i == 2) check("f_at_max", int'(f_at_max), 1);
    end
    repeat (3) pulse(M_FDN);
    check("fdown_to_4", int'(f), 4);

    repeat (3) pulse(M_FDN);
    req = M_FDN;
    @(negedge clk);
    req = '0;
    check("f_reaches_0", int'(f), 0);
    check("a_at_f0", int'(a), 4);
    repeat (3) @(negedge clk);
    check("a_before_first_decay", int'(a), 4);
    @(negedge clk);
    check("a_first_decay", int'(a), 3);
    pulse(M_FUP);
    check("f_latched_0", int'(f), 0);
    repeat (30) @(negedge clk);
    check("a_decayed_0", int'(a), 0);
    check("stopped_set", int'(stopped), 1);

    pulse(M_STA);
    check("restart_f", int'(f), FINIT);
    check("restart_a", int'(a), AINIT);
    pulse(M_AUP);
    pulse(M_FUP);
    pulse(M_STA);
    check("start_running_f", int'(f), 5);
    check("start_running_a", int'(a), 5);
    pulse(M_FUP | M_FDN);
    check("fup_fdown_same", int'(f), 5);

    repeat (4) pulse(M_FDN);
    req = M_FDN;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    check("a_before_tick", int'(a), 5);
    req = M_ADN;
    @(negedge clk);
    check("adown_on_tick", int'(a), 4);
    req = '0;
    @(negedge clk);
    pulse(M_AUP);
    check("aup_ignored_f0", int'(a), 4);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_decay_reset_f", int'(f), FINIT);
    check("mid_decay_reset_a", int'(a), AINIT);
    @(negedge clk);
    reset = 1'b0;

    repeat (800) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 30) req[0] = ~req[0];
      if ($urandom_range(0, 99) < 25) req[1] = ~req[1];
      if ($urandom_range(0, 99) < 30) req[2] = ~req[2];
      if ($urandom_range(0, 99) < 25) req[3] = ~req[3];
      if ($urandom_range(0, 99) < 15) req[4] = ~req[4];
    end
    req = '0;
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_regulator.md
FA_REGULATOR -- requirements
Module: fa_regulator

Interface
REQ-001 SHALL have parameter W, default 3: width of the f and a counters.
REQ-002 SHALL have parameter F_INIT, default 4: f value after reset and after restart.
REQ-003 SHALL have parameter A_INIT, default 4: a value after reset and after restart.
REQ-004 SHALL have parameter A_MAX, default 2**W-1: upper saturation limit of a.
REQ-005 SHALL have parameter DECAY_CYC, default 4: clk cycles between auto-decrements of a while f==0; legal range >=1.
REQ-006 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-007 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have ports f_up, f_down, a_up, a_down, input, 1 each: level requests; one step per rising edge of the level.
REQ-009 SHALL have port start, input, 1: level request; a rising edge restarts the block when stopped.
REQ-010 SHALL have ports f and a, output, W each: registered frequency and amplitude.
REQ-011 SHALL have ports f_zero, a_zero, f_at_max, a_at_max, stopped, output, 1 each: combinational flags f==0, a==0, f==2**W-1, a==A_MAX, f_zero&&a_zero.

Function
REQ-012 Each request input SHALL be edge-detected: a request is an event at a clk edge where the input samples 1 and sampled 0 at the previous edge.
REQ-013 Counter updates SHALL take effect at the same clk edge that detects the event (zero added latency); holding an input high SHALL give exactly one step.
REQ-014 f_up event SHALL increment f; at 2**W-1, f SHALL hold (no wrap).
REQ-015 f_down event SHALL decrement f; f==0 SHALL never be reached by wrap.
REQ-016 f_up and f_down events in the same cycle SHALL leave f unchanged.
REQ-017 Once f==0, f SHALL latch at 0 and ignore f_up/f_down until restart or reset.
REQ-018 a_up event SHALL increment a, saturating at A_MAX; a_up SHALL be ignored while f==0.
REQ-019 a_down event SHALL decrement a, saturating at 0.
REQ-020 a_up and a_down events in the same cycle SHALL leave a unchanged.
REQ-021 While f==0 and a!=0, a decay counter SHALL count clk cycles, and a SHALL decrement by 1 every DECAY_CYC-th cycle; the first decrement SHALL occur DECAY_CYC cycles after f becomes 0.
REQ-022 The decay counter SHALL be held at 0 while f!=0 or a==0.
REQ-023 An a_down event coinciding with a decay tick SHALL decrement a by 1 only.
REQ-024 A start event while stopped==1 SHALL load f=F_INIT, a=A_INIT and clear the decay counter; a start event while stopped==0 SHALL be ignored.
REQ-025 A start event SHALL take priority over all other events in the same cycle.

Reset
REQ-026 Reset assertion SHALL immediately force f=F_INIT, a=A_INIT and decay counter=0, independent of clk.
REQ-027 Edge-history flops SHALL reset to 1, so an input held high through reset release produces no event.
REQ-028 All flags SHALL be valid immediately after reset; with defaults: f_zero=0, a_zero=0, stopped=0.

Structure
REQ-029 Package fa_pkg SHALL hold the default parameter values and a function computing the decay-counter width (clog2 of DECAY_CYC, minimum 1).
REQ-030 Sub-module edge_det (one history flop, rise output, parameterised reset value) SHALL be instantiated once per request input.
REQ-031 Elaboration SHALL fail if F_INIT>2**W-1, A_INIT>A_MAX, A_MAX>2**W-1, or DECAY_CYC<1.

Verification (W=3, F_INIT=4, A_INIT=4, A_MAX=7, DECAY_CYC=4)
REQ-032 Reset with f_up held high, then release reset -> f=4, a=4, stopped=0; no step occurs from the held input.
REQ-033 Five f_up pulses -> f steps 5,6,7,7,7; f_at_max=1 after the third pulse.
REQ-034 f_down held high for 10 cycles -> f=3 after the first edge, then unchanged.
REQ-035 Four f_down pulses from f=4 -> f=0; later f_up pulse leaves f at 0; a steps 4,3,2,1,0 at 4-cycle intervals; then stopped=1.
REQ-036 Same-cycle f_up+f_down edges -> f unchanged; a_down edge on a decay tick -> a decreases by exactly 1.
REQ-037 start pulse while stopped -> f=4, a=4 at that edge; start pulse while running -> no change; reset asserted mid-decay -> f=4, a=4 immediately.
